// File: rtl/led_blink_ctrl.sv
// Status LED controller: a shared period down-counter drives CHANNELS LED lanes
// (off/on/blink/pulse) plus an 8-bit status bank that mirrors the core's code byte.

module led_blink_lane #(
  parameter int CW       = 32,
  parameter int BOARD_CK = 50000000,
  parameter int IDX      = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [1:0]    wmode,
  input  logic [4:0]    wtap,
  input  logic [CW-1:0] cnt,
  output logic          led
);
  localparam logic [CW-1:0] PULSE_TH = CW'(BOARD_CK - BOARD_CK / 8);

  logic [1:0]    mode;
  logic [4:0]    tap;
  logic [CW-1:0] sh;
  logic          nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode <= 2'd2;
      tap  <= 5'(24 - IDX);
    end else if (we) begin
      mode <= wmode;
      tap  <= wtap;
    end
  end

  // Shifting by tap >= CW yields zero, which is the required blink output there.
  always_comb begin
    sh  = cnt >> tap;
    nxt = 1'b0;
    case (mode)
      2'd0:    nxt = 1'b0;
      2'd1:    nxt = 1'b1;
      2'd2:    nxt = sh[0];
      default: nxt = (cnt >= PULSE_TH);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) led <= 1'b0;
    else       led <= nxt;
  end
endmodule

module led_blink_ctrl #(
  parameter int CHANNELS = 3,
  parameter int BOARD_CK = 50000000,
  parameter int CW       = 32,
  localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          code,
  input  logic                cfg_we,
  input  logic [CHW-1:0]      cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [4:0]          cfg_tap,
  output logic [CHANNELS-1:0] led,
  output logic [7:0]          leds,
  output logic                test_mode,
  output logic                tick
);
  localparam logic [CW-1:0] RELOAD = CW'(BOARD_CK - 1);
  localparam logic [CW-1:0] HALF   = CW'(BOARD_CK / 2);

  logic [CW-1:0]       cnt;
  logic                restart;
  logic [CHANNELS-1:0] wr;

  assign restart = (code == 8'h52);

  // Restart holds the counter at zero; the reload on zero preempts any decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == '0) && !restart;
      if (restart)          cnt <= '0;
      else if (cnt == '0)   cnt <= RELOAD;
      else                  cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      test_mode <= 1'b0;
      leds      <= 8'h00;
    end else begin
      test_mode <= (code == 8'h54);
      leds      <= test_mode ? ((cnt < HALF) ? 8'hFF : 8'h00) : code;
    end
  end

  // Out-of-range channel indices match no lane and are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    assign wr[i] = cfg_we && (32'(cfg_ch) == i);
    led_blink_lane #(.CW(CW), .BOARD_CK(BOARD_CK), .IDX(i)) u_lane (
      .clk   (clk),
      .reset (reset),
      .we    (wr[i]),
      .wmode (cfg_mode),
      .wtap  (cfg_tap),
      .cnt   (cnt),
      .led   (led[i])
    );
  end
endmodule

// File: tb/tb_led_blink_ctrl.sv
// Bench for led_blink_ctrl: two instances (CW=32 and CW=4) share stimulus and are
// checked every cycle against a period-position model plus directed literal checks.

module tb_led_blink_ctrl;
  localparam int CH  = 3;
  localparam int BCK = 16;

  logic       clk = 1'b0, reset = 1'b0, cfg_we = 1'b0, go = 1'b0;
  logic [7:0] code = 8'h00;
  logic [1:0] cfg_ch = 2'd0, cfg_mode = 2'd0;
  logic [4:0] cfg_tap = 5'd0;
  logic [2:0] led_a, led_b;
  logic [7:0] leds_a, leds_b;
  logic       tm_a, tm_b, tick_a, tick_b;

  led_blink_ctrl #(.CHANNELS(CH), .BOARD_CK(BCK), .CW(32)) dut_a (
    .clk(clk), .reset(reset), .code(code), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_tap(cfg_tap), .led(led_a), .leds(leds_a),
    .test_mode(tm_a), .tick(tick_a));

  led_blink_ctrl #(.CHANNELS(CH), .BOARD_CK(BCK), .CW(4)) dut_b (
    .clk(clk), .reset(reset), .code(code), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_tap(cfg_tap), .led(led_b), .leds(leds_b),
    .test_mode(tm_b), .tick(tick_b));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: age counts edges since the counter last sat at zero; the counter value
  // is then its position within the period, counting down from BCK-1.
  int         age = 0;
  int         mmode [CH];
  int         mtap  [CH];
  logic [2:0] e_led_a = '0, e_led_b = '0;
  logic [7:0] e_leds = '0;
  logic       e_tm = 1'b0, e_tick = 1'b0;

  function automatic int mcnt();
    return (age == 0) ? 0 : BCK - 1 - ((age - 1) % BCK);
  endfunction

  function automatic logic lane(input int m, input int t, input int c, input int cw);
    case (m)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (t < cw) ? 1'((c >> t) & 1) : 1'b0;
      default: return (c >= BCK - BCK / 8);
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      age <= 0;
      for (int i = 0; i < CH; i++) begin
        mmode[i] <= 2;
        mtap[i]  <= 24 - i;
      end
      e_led_a <= '0; e_led_b <= '0; e_leds <= '0; e_tm <= 1'b0; e_tick <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        e_led_a[i] <= lane(mmode[i], mtap[i], mcnt(), 32);
        e_led_b[i] <= lane(mmode[i], mtap[i], mcnt(), 4);
      end
      e_tick <= (mcnt() == 0) && (code != 8'h52);
      e_leds <= e_tm ? ((mcnt() < BCK / 2) ? 8'hFF : 8'h00) : code;
      e_tm   <= (code == 8'h54);
      age    <= (code == 8'h52) ? 0 : age + 1;
      if (cfg_we && int'(cfg_ch) < CH) begin
        mmode[cfg_ch] <= int'(cfg_mode);
        mtap[cfg_ch]  <= int'(cfg_tap);
      end
    end
  end

  always @(negedge clk) begin
    if (go) begin
      chk("led_a",  led_a,  e_led_a);
      chk("led_b",  led_b,  e_led_b);
      chk("leds_a", leds_a, e_leds);
      chk("leds_b", leds_b, e_leds);
      chk("tick_a", tick_a, e_tick);
      chk("tick_b", tick_b, e_tick);
      chk("tm_a",   tm_a,   e_tm);
      chk("tm_b",   tm_b,   e_tm);
    end
  end

  task automatic wr(input logic [1:0] ch, input logic [1:0] m, input logic [4:0] t);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = m; cfg_tap = t;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  initial begin
    int n, k, pa, pb;
    #1 reset = 1'b1;
    go = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {led_a, leds_a, tick_a, tm_a}, 32'd0);
    reset = 1'b0;

    n = 0;
    repeat (48) begin @(negedge clk); n += int'(tick_a); end
    chk("tick_count_48", n, 3);

    wr(2'd1, 2'd3, 5'd0);
    repeat (2) @(negedge clk);
    n = 0;
    repeat (16) begin @(negedge clk); n += int'(led_a[1]); end
    chk("pulse_high_cycles", n, 2);

    wr(2'd0, 2'd2, 5'd2);
    repeat (2) @(negedge clk);
    pa = int'(led_a[0]); pb = int'(led_b[0]); n = 0; k = 0;
    repeat (16) begin
      @(negedge clk);
      n += int'(int'(led_a[0]) != pa); pa = int'(led_a[0]);
      k += int'(int'(led_b[0]) != pb); pb = int'(led_b[0]);
    end
    chk("blink_toggles_a", n, 4);
    chk("blink_toggles_b", k, 4);

    wr(2'd0, 2'd2, 5'd31);
    repeat (2) @(negedge clk);
    n = 0;
    repeat (16) begin @(negedge clk); n += int'(led_a[0]) + int'(led_b[0]); end
    chk("tap31_dark", n, 0);

    wr(2'd3, 2'd1, 5'd0);
    repeat (2) @(negedge clk);
    n = 0;
    repeat (16) begin @(negedge clk); n += int'(led_a[0]) + int'(led_a[2]); end
    chk("bad_ch_ignored", n, 0);

    code = 8'h52;
    n = 0;
    repeat (5) begin @(negedge clk); n += int'(tick_a); end
    chk("restart_no_tick", n, 0);
    code = 8'h00;
    @(negedge clk);
    chk("restart_release_tick", tick_a, 1);

    code = 8'h54;
    @(negedge clk);
    chk("test_mode_set", tm_a, 1);
    @(negedge clk);
    n = 0;
    repeat (16) begin @(negedge clk); n += int'(leds_a == 8'hFF); end
    chk("test_ff_cycles", n, 8);
    code = 8'hA5;
    repeat (2) @(negedge clk);
    chk("leds_follow_code", leds_a, 32'hA5);

    code = 8'h00;
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_mode = 2'd1; cfg_tap = 5'd0;
    #2 reset = 1'b1;
    #1 chk("async_reset", {led_a, leds_a, tick_a, tm_a, led_b, leds_b}, 32'd0);
    cfg_we = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_partial_cfg", led_a[2], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
